// File: rtl/uart_tx_unit_pkg.sv
// Shared UART definitions: FSM state encoding, oversample ratio
// and the baud divider derivation reused by the receiver.
package uart_tx_unit_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } tx_state_e;

  // Clocks per oversample tick, integer division.
  function automatic int baud_div(
    input int clk_freq,
    input int baud
  );
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_tx_unit_baud_tick_gen.sv
// Oversample tick generator: counts 0..DIV-1, tick on DIV-1.
// Ports: clk, rst (async low), clr (sync restart), tick.
module baud_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_unit.sv
// 8N1 UART transmitter with internal baud divider, LSB first.
// Ports: clk, rst (async low), i_tx_data, is_tx_start, o_tx, os_tx_done, o_busy.
module uart_tx_unit
  import uart_tx_unit_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int SB_TICK   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 is_tx_start,
  output logic                 o_tx,
  output logic                 os_tx_done,
  output logic                 o_busy
);

  localparam int DIV_RAW = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;

  localparam logic [4:0] LAST_TICK = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_e            state, state_n;
  logic [4:0]           tick_cnt, tick_n;
  logic [2:0]           bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, sh_n;
  logic                 tick;
  logic                 accept;
  logic                 finish;
  logic                 fin_d;
  logic                 tx_n;

  baud_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .tick(tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shreg    <= sh_n;
    end
  end

  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    accept  = 1'b0;
    finish  = 1'b0;
    tx_n    = 1'b1;
    unique case (state)
      IDLE: begin
        if (is_tx_start) begin
          accept  = 1'b1;
          state_n = START;
          tick_n  = '0;
          sh_n    = i_tx_data;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (tick) begin
          if (tick_cnt == LAST_TICK) begin
            tick_n  = '0;
            bit_n   = '0;
            state_n = DATA;
          end else begin
            tick_n = tick_cnt + 5'd1;
          end
        end
      end
      DATA: begin
        tx_n = shreg[0];
        if (tick) begin
          if (tick_cnt == LAST_TICK) begin
            tick_n = '0;
            sh_n   = shreg >> 1;
            if (bit_cnt == LAST_BIT) begin
              state_n = STOP;
            end else begin
              bit_n = bit_cnt + 3'd1;
            end
          end else begin
            tick_n = tick_cnt + 5'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tick_cnt == STOP_LAST) begin
            tick_n  = '0;
            state_n = IDLE;
            finish  = 1'b1;
          end else begin
            tick_n = tick_cnt + 5'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Line follows the state one clock later; done and busy-clear
  // are delayed to line up with the end of that registered bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_tx       <= 1'b1;
      fin_d      <= 1'b0;
      os_tx_done <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_tx       <= tx_n;
      fin_d      <= finish;
      os_tx_done <= fin_d;
      o_busy     <= accept | (o_busy & ~fin_d);
    end
  end

endmodule

// File: tb/tb_uart_tx_unit.sv
// Randomised scoreboard bench for uart_tx_unit (DIV=1, 16 clocks/bit).
// Serial capture and done monitors check against queued expectations.
module tb_uart_tx_unit;

  localparam int B     = 16;
  localparam int FRAME = 10 * B + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] i_tx_data = '0;
  logic       is_tx_start = 1'b0;
  logic       o_tx;
  logic       os_tx_done;
  logic       o_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int epoch = 0;
  int last_k = -1000;
  int next_free = 0;
  int accepts = 0;
  int done_cnt = 0;

  logic [7:0] byte_q[$];
  int         t0_q[$];
  int         done_q[$];

  uart_tx_unit #(
    .CLK_FREQ (50_000_000),
    .BAUD_RATE(3_125_000),
    .DATA_BITS(8),
    .SB_TICK  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_tx_data  (i_tx_data),
    .is_tx_start(is_tx_start),
    .o_tx       (o_tx),
    .os_tx_done (os_tx_done),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a frame is accepted on an edge where start is
  // high and the previous accept was at least FRAME clocks earlier.
  task automatic drive(input logic st, input logic [7:0] d, output bit acc);
    int e;
    acc = 1'b0;
    is_tx_start = st;
    i_tx_data = d;
    e = cyc + 1;
    if (st && rst && e >= next_free) begin
      acc = 1'b1;
      byte_q.push_back(d);
      t0_q.push_back(e + 1);
      done_q.push_back(e + FRAME);
      last_k = e;
      next_free = e + FRAME;
      accepts++;
    end
    @(posedge clk);
    @(negedge clk);
    chk("busy", int'(o_busy), int'(cyc >= last_k && cyc < last_k + FRAME));
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) drive(1'b0, 8'($urandom), a);
  endtask

  task automatic send(input logic [7:0] d, output int k);
    bit a;
    a = 1'b0;
    for (int i = 0; i < 400 && !a; i++) drive(1'b1, d, a);
    k = last_k;
    if (!a) chk("send_timeout", 0, 1);
    is_tx_start = 1'b0;
  endtask

  // Serial capture: mid-bit sampling from the first low sample.
  initial begin : serial_mon
    int t0, ep;
    logic sb, pb;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst && o_tx === 1'b0) begin
        t0 = cyc;
        ep = epoch;
        repeat (8) @(negedge clk);
        sb = o_tx;
        for (int n = 0; n < 8; n++) begin
          repeat (B) @(negedge clk);
          b[n] = o_tx;
        end
        repeat (B) @(negedge clk);
        pb = o_tx;
        if (ep == epoch) begin
          if (byte_q.size() == 0) begin
            chk("unexpected_frame", int'(b), -1);
          end else begin
            chk("start_bit", int'(sb), 0);
            chk("frame_byte", int'(b), int'(byte_q.pop_front()));
            chk("frame_start", t0, t0_q.pop_front());
            chk("stop_bit", int'(pb), 1);
          end
        end
      end
    end
  end

  initial begin : done_mon
    forever begin
      @(negedge clk);
      if (os_tx_done === 1'b1) begin
        done_cnt++;
        if (done_q.size() == 0) chk("unexpected_done", cyc, -1);
        else chk("done_time", cyc, done_q.pop_front());
      end
    end
  end

  initial begin : stim
    int k, k2, d0;
    bit a;
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(o_tx), 1);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(os_tx_done), 0);
    rst = 1'b1;
    // 1: idle after reset
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 8'($urandom), a);
      chk("idle_tx", int'(o_tx), 1);
      chk("idle_done", int'(os_tx_done), 0);
    end
    // 2: single frame
    send(8'hA5, k);
    idle(200);
    // 3: start while busy is ignored
    send(8'h3C, k);
    while (cyc + 1 < k + 50) drive(1'b0, 8'($urandom), a);
    drive(1'b1, 8'hFF, a);
    chk("ignored_start", int'(a), 0);
    idle(250);
    // 4: held start, back-to-back
    send(8'h01, k);
    is_tx_start = 1'b1;
    send(8'h80, k2);
    chk("b2b_period", k2 - k, FRAME);
    idle(250);
    // 5: async reset mid data bit 3
    send(8'hC3, k);
    while (cyc < k + 69) drive(1'b0, 8'($urandom), a);
    #2 rst = 1'b0;
    #1;
    chk("arst_tx", int'(o_tx), 1);
    chk("arst_busy", int'(o_busy), 0);
    epoch++;
    accepts -= done_q.size();
    byte_q.delete();
    t0_q.delete();
    done_q.delete();
    last_k = -1000;
    next_free = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(200);
    send(8'h55, k);
    idle(200);
    // 6: 256 random bytes back-to-back, data scrambled every clock
    d0 = done_cnt;
    k2 = 0;
    while (k2 < 256) begin
      drive(1'b1, 8'($urandom), a);
      if (a) k2++;
    end
    is_tx_start = 1'b0;
    for (int i = 0; i < 400 && (done_q.size() != 0 || byte_q.size() != 0); i++)
      idle(1);
    idle(20);
    chk("drain_bytes", byte_q.size(), 0);
    chk("drain_done", done_q.size(), 0);
    chk("burst_done_pulses", done_cnt - d0, 256);
    chk("total_done_pulses", done_cnt, accepts);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
